sr_multi_rw_engine: RTL and testbench
=====================================

Name: sr_multi_rw_engine

Overview:
- Multi-channel successor to the single-chain shift-register config/readback controller.
- Drives NCH on-chip configuration shift registers in parallel from one divided serial clock. Writes a WIDTH-bit word per channel, pulses load, and captures the bits shifted out of each chain.
- Adds a per-channel enable mask, readback-vs-previous-write compare, and a busy flag.
- Sits between the control register file and the LVDS I/O buffers; outputs are single-ended, and differential buffering is external.

Parameters:
- WIDTH, 170: bits per chain; WIDTH <= 2**CNT_WIDTH.
- CNT_WIDTH, 8: bit-counter width.
- DIV_WIDTH, 6: width of div.
- NCH, 2: number of parallel chains.
- SHIFT_DIRECTION, 1: 1 = MSB out/in first; 0 = LSB first.
- READ_DELAY, 0: extra half-periods between end of load and valid.

Ports:
- clk_in  in  1  sole clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request pulse, already synchronous to clk_in.
- din  in  NCH*WIDTH  config words; channel c occupies bits [c*WIDTH +: WIDTH].
- ch_mask  in  NCH  1 = channel active.
- div  in  DIV_WIDTH  half-period H = 2**div clk_in cycles.
- sr_data_in  in  NCH  serial data returned from each chain.
- sr_clk  out  1  serial clock to all chains.
- sr_data_out  out  NCH  serial data to each chain.
- sr_load  out  1  load strobe to all chains.
- busy  out  1  transaction in progress.
- valid  out  1  one-cycle pulse: dout and mismatch updated.
- dout  out  NCH*WIDTH  captured readback words.
- mismatch  out  NCH  per-channel readback != previously written word.

Behaviour:
- Reset (asynchronous, rst_n low) drives outputs and state as follows:
  - sr_clk = 0, sr_data_out = 0, sr_load = 0.
  - busy = 0, valid = 0, dout = 0, mismatch = 0.
  - shadow = 0, armed = 0, FSM -> IDLE.
  - Reset asserted mid-transaction aborts immediately. Outputs return to reset values on the same edge; no partial dout is presented.
- FSM states: IDLE -> SHIFT -> LOAD -> DELAY -> DONE -> IDLE.
- IDLE:
  - start = 1 latches din, ch_mask and div, then enters SHIFT.
  - busy rises on the next cycle.
  - start while busy is ignored (no queuing).
- SHIFT:
  - A half-period counter generates a tick every H cycles.
  - Each bit lasts 2H cycles: H with sr_clk low, then H with sr_clk high.
  - The new bit is driven at the start of the low phase.
  - sr_data_in is sampled on the clk_in cycle where sr_clk rises.
  - After WIDTH rising edges, sr_clk returns low and the FSM goes to LOAD.
  - Bit order follows SHIFT_DIRECTION; captured bits fill dout in the same order, so chain contents round-trip unchanged.
- LOAD: sr_load = 1 for 2H cycles with sr_clk held low.
- DELAY: READ_DELAY*H cycles; skipped when READ_DELAY = 0.
- DONE:
  - valid = 1 for exactly one cycle.
  - dout updates for active channels; masked channels keep their previous dout.
  - mismatch[c] = armed & ch_mask[c] & (capture_c != shadow_c).
  - shadow of active channels <= latched din; armed <= 1.
  - busy falls on the cycle after DONE.
- Masked channels: sr_data_out[c] held 0 for the whole transaction; mismatch[c] = 0.
- Latency: start to valid = 2H*WIDTH + 2H + READ_DELAY*H + 1 cycles.
- div = 0 is legal (H = 1). Changing div or din while busy has no effect until the next start.
- mismatch is held until the next valid pulse.

Optional Feature:
- Macro: SR_LOOPBACK_EN.
- When defined:
  - Adds input port loopback (1 bit, sampled at start).
  - If latched loopback = 1, each channel's capture samples its own sr_data_out register instead of sr_data_in, so dout == din for active channels.
  - sr_clk and sr_load still toggle as normal.
- When undefined: the port is absent and capture always uses sr_data_in.

Test Plan:
- Basic write. Setup: WIDTH=8, NCH=2, div=0, mask=2'b11, din={8'hA5,8'h3C}, chains modelled as 8-bit shifters initially 0.
  - sr_data_out[0] bits, in order: 0,0,1,1,1,1,0,0.
  - valid exactly 19 cycles after start; dout = 0; mismatch = 0 (not armed).
- Readback compare. Repeat the transaction with din={8'hFF,8'h00}.
  - dout = {8'hA5,8'h3C}; mismatch = 2'b00.
  - Corrupt chain 1 to 8'hA4, then run again: mismatch = 2'b10.
- Mask and divider. div=2 (H=4), mask=2'b01.
  - sr_clk period 8 cycles; sr_load high 8 cycles.
  - sr_data_out[1] stays 0; dout[15:8] unchanged.
  - valid at 2*4*8 + 8 + 1 = 73 cycles.
- Start while busy. Second start pulse at cycle 5.
  - Ignored: only one valid pulse; busy high continuously from cycle 1 to the valid cycle.
- Reset mid-shift. rst_n low at cycle 7.
  - All outputs 0 immediately; FSM in IDLE.
  - A new start gives full-length timing and mismatch = 0.
- Loopback (SR_LOOPBACK_EN defined). loopback=1, din={8'h5A,8'hC3}.
  - dout = {8'h5A,8'hC3}, independent of sr_data_in.

Source files
------------

// File: rtl/sr_multi_rw_engine_if.sv
// rtl/sr_multi_rw_engine_if.sv - request, result and serial chain signals of sr_multi_rw_engine
// Optional SR_LOOPBACK_EN adds the loopback request bit.
interface sr_multi_rw_engine_if #(
   parameter int WIDTH     = 170,
   parameter int NCH       = 2,
   parameter int DIV_WIDTH = 6
);
   logic                   start;
   logic [NCH*WIDTH-1:0]   din;
   logic [NCH-1:0]         ch_mask;
   logic [DIV_WIDTH-1:0]   div;
`ifdef SR_LOOPBACK_EN
   logic                   loopback;
`endif
   logic [NCH-1:0]         sr_data_in;
   logic                   sr_clk;
   logic [NCH-1:0]         sr_data_out;
   logic                   sr_load;
   logic                   busy;
   logic                   valid;
   logic [NCH*WIDTH-1:0]   dout;
   logic [NCH-1:0]         mismatch;

`ifdef SR_LOOPBACK_EN
   modport master (
      output start, din, ch_mask, div, loopback, sr_data_in,
      input  sr_clk, sr_data_out, sr_load, busy, valid, dout, mismatch
   );
   modport slave (
      input  start, din, ch_mask, div, loopback, sr_data_in,
      output sr_clk, sr_data_out, sr_load, busy, valid, dout, mismatch
   );
`else
   modport master (
      output start, din, ch_mask, div, sr_data_in,
      input  sr_clk, sr_data_out, sr_load, busy, valid, dout, mismatch
   );
   modport slave (
      input  start, din, ch_mask, div, sr_data_in,
      output sr_clk, sr_data_out, sr_load, busy, valid, dout, mismatch
   );
`endif
endinterface

// File: rtl/sr_multi_rw_engine.sv
// rtl/sr_multi_rw_engine.sv - multi-channel shift-register config writer with readback capture and compare
// Optional SR_LOOPBACK_EN: latched loopback makes each capture sample its own sr_data_out register.
module sr_multi_rw_engine #(
   parameter int WIDTH           = 170,
   parameter int CNT_WIDTH       = 8,
   parameter int DIV_WIDTH       = 6,
   parameter int NCH             = 2,
   parameter int SHIFT_DIRECTION = 1,
   parameter int READ_DELAY      = 0
) (
   input  logic                 clk_in,
   input  logic                 rst_n,
   sr_multi_rw_engine_if.slave  bus
);

   // Half-period counter must reach 2**div - 1 for any div value.
   localparam int HW = 1 << DIV_WIDTH;
   // One spare bit so the rising-edge count can hold WIDTH itself.
   localparam int BW = CNT_WIDTH + 1;
   localparam int DW = 16;
   localparam int FIRST_IDX = (SHIFT_DIRECTION != 0) ? WIDTH - 1 : 0;

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] SHIFT = 3'd1;
   localparam logic [2:0] LOAD  = 3'd2;
   localparam logic [2:0] DELAY = 3'd3;
   localparam logic [2:0] DONE  = 3'd4;

   logic [2:0]             state;
   logic [HW-1:0]          hcnt;
   logic [HW-1:0]          hmask;
   logic                   phase;
   logic [BW-1:0]          bcnt;
   logic [DW-1:0]          dcnt;
   logic [NCH*WIDTH-1:0]   din_l;
   logic [NCH-1:0]         mask_l;
   logic [NCH*WIDTH-1:0]   cap;
   logic [NCH*WIDTH-1:0]   cap_next;
   logic [NCH*WIDTH-1:0]   shadow;
   logic                   armed;
   logic                   sr_clk_r;
   logic [NCH-1:0]         sr_do_r;
   logic                   sr_load_r;
   logic                   busy_r;
   logic                   valid_r;
   logic [NCH*WIDTH-1:0]   dout_r;
   logic [NCH-1:0]         mm_r;
   logic [NCH-1:0]         cap_in;
   logic [NCH-1:0]         first_bits;
   logic [NCH-1:0]         next_bits;
   logic [BW-1:0]          bit_idx;
   logic                   tick;
   logic                   finish;
   logic                   accept;
`ifdef SR_LOOPBACK_EN
   logic                   lb_l;
`endif

   assign bus.sr_clk      = sr_clk_r;
   assign bus.sr_data_out = sr_do_r;
   assign bus.sr_load     = sr_load_r;
   assign bus.busy        = busy_r;
   assign bus.valid       = valid_r;
   assign bus.dout        = dout_r;
   assign bus.mismatch    = mm_r;

   assign accept = (state == IDLE) && bus.start;
   assign tick   = (hcnt == hmask);

   // Last tick of LOAD ends the transaction directly when no read delay is configured.
   assign finish = (tick && phase && (state == LOAD) && (READ_DELAY == 0)) ||
                   (tick && (state == DELAY) && (dcnt == DW'(READ_DELAY - 1)));

   // bcnt counts completed rising edges, so it names the next bit to drive.
   assign bit_idx = (bcnt >= BW'(WIDTH)) ? '0 :
                    (SHIFT_DIRECTION != 0) ? (BW'(WIDTH - 1) - bcnt) : bcnt;

   // Per-channel serial bit selection and capture source.
   always_comb begin
      first_bits = '0;
      next_bits  = '0;
      cap_in     = '0;
      for (int c = 0; c < NCH; c++) begin
         first_bits[c] = bus.ch_mask[c] & bus.din[c*WIDTH + FIRST_IDX];
         next_bits[c]  = mask_l[c] & din_l[c*WIDTH + int'(bit_idx)];
`ifdef SR_LOOPBACK_EN
         cap_in[c]     = lb_l ? sr_do_r[c] : bus.sr_data_in[c];
`else
         cap_in[c]     = bus.sr_data_in[c];
`endif
      end
   end

   // Captured bits fill each word in the same order they were sent, so contents round-trip.
   always_comb begin
      cap_next = cap;
      for (int c = 0; c < NCH; c++) begin
         if (SHIFT_DIRECTION != 0)
            cap_next[c*WIDTH +: WIDTH] = {cap[c*WIDTH +: WIDTH-1], cap_in[c]};
         else
            cap_next[c*WIDTH +: WIDTH] = {cap_in[c], cap[c*WIDTH+1 +: WIDTH-1]};
      end
   end

   // Request latch: din, mask, divider (and loopback) are frozen for the whole transaction.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         din_l  <= '0;
         mask_l <= '0;
         hmask  <= '0;
`ifdef SR_LOOPBACK_EN
         lb_l   <= 1'b0;
`endif
      end else if (accept) begin
         din_l  <= bus.din;
         mask_l <= bus.ch_mask;
         hmask  <= (HW'(1) << bus.div) - HW'(1);
`ifdef SR_LOOPBACK_EN
         lb_l   <= bus.loopback;
`endif
      end
   end

   // Half-period timer: free-runs outside IDLE and wraps on every tick.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n)
         hcnt <= '0;
      else if (state == IDLE || tick)
         hcnt <= '0;
      else
         hcnt <= hcnt + HW'(1);
   end

   // Sequencer: serial clock, data, load strobe and busy/valid.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         phase     <= 1'b0;
         bcnt      <= '0;
         dcnt      <= '0;
         sr_clk_r  <= 1'b0;
         sr_do_r   <= '0;
         sr_load_r <= 1'b0;
         busy_r    <= 1'b0;
         valid_r   <= 1'b0;
      end else begin
         valid_r <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  state    <= SHIFT;
                  busy_r   <= 1'b1;
                  phase    <= 1'b0;
                  bcnt     <= '0;
                  sr_clk_r <= 1'b0;
                  sr_do_r  <= first_bits;
               end
            end
            SHIFT: begin
               if (tick) begin
                  if (!phase) begin
                     sr_clk_r <= 1'b1;
                     phase    <= 1'b1;
                     bcnt     <= bcnt + BW'(1);
                  end else if (bcnt == BW'(WIDTH)) begin
                     sr_clk_r  <= 1'b0;
                     sr_do_r   <= '0;
                     phase     <= 1'b0;
                     sr_load_r <= 1'b1;
                     state     <= LOAD;
                  end else begin
                     sr_clk_r <= 1'b0;
                     phase    <= 1'b0;
                     sr_do_r  <= next_bits;
                  end
               end
            end
            LOAD: begin
               if (tick) begin
                  if (!phase) begin
                     phase <= 1'b1;
                  end else begin
                     phase     <= 1'b0;
                     sr_load_r <= 1'b0;
                     dcnt      <= '0;
                     if (finish) begin
                        state   <= DONE;
                        valid_r <= 1'b1;
                     end else begin
                        state <= DELAY;
                     end
                  end
               end
            end
            DELAY: begin
               if (finish) begin
                  state   <= DONE;
                  valid_r <= 1'b1;
               end else if (tick) begin
                  dcnt <= dcnt + DW'(1);
               end
            end
            DONE: begin
               state  <= IDLE;
               busy_r <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Readback shift register: samples on the cycle where sr_clk rises.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n)
         cap <= '0;
      else if (state == SHIFT && tick && !phase)
         cap <= cap_next;
   end

   // Results: active channels update dout and shadow; masked channels never report a mismatch.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         dout_r <= '0;
         mm_r   <= '0;
         shadow <= '0;
         armed  <= 1'b0;
      end else if (finish) begin
         armed <= 1'b1;
         for (int c = 0; c < NCH; c++) begin
            mm_r[c] <= armed & mask_l[c] &
                       (cap[c*WIDTH +: WIDTH] != shadow[c*WIDTH +: WIDTH]);
            if (mask_l[c]) begin
               dout_r[c*WIDTH +: WIDTH] <= cap[c*WIDTH +: WIDTH];
               shadow[c*WIDTH +: WIDTH] <= din_l[c*WIDTH +: WIDTH];
            end
         end
      end
   end

endmodule

// File: tb/tb_sr_multi_rw_engine.sv
// tb/tb_sr_multi_rw_engine.sv - scoreboard bench for sr_multi_rw_engine with 8-bit chain models
module tb_sr_multi_rw_engine;

   typedef struct {
      string       tag;
      int          base;
      int          lat;
      logic [15:0] dout;
      logic [1:0]  mm;
      logic [15:0] chain;
      int          ld;
      int          chi;
      logic [1:0]  dor;
   } exp_t;

   typedef struct {
      string       name;
      logic [63:0] act;
      logic [63:0] exp;
   } chk_t;

   logic clk;
   logic rst_n;
   int   cyc;
   int   vcnt;
   int   v0;
   int   n_vec;
   int   n_bad;
   exp_t sbq[$];
   chk_t chkq[$];

   logic       preset;
   logic [7:0] pv0, pv1;
   logic [7:0] chain0, chain1;

   sr_multi_rw_engine_if #(.WIDTH(8), .NCH(2), .DIV_WIDTH(6)) bus ();

   sr_multi_rw_engine #(
      .WIDTH(8), .CNT_WIDTH(8), .DIV_WIDTH(6), .NCH(2),
      .SHIFT_DIRECTION(1), .READ_DELAY(0)
   ) dut (
      .clk_in(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Two 8-bit MSB-first chains; preset forces their contents.
   always @(posedge bus.sr_clk or posedge preset) begin
      if (preset) begin
         chain0 <= pv0;
         chain1 <= pv1;
      end else begin
         chain0 <= {chain0[6:0], bus.sr_data_out[0]};
         chain1 <= {chain1[6:0], bus.sr_data_out[1]};
      end
   end
   assign bus.sr_data_in = {chain1[7], chain0[7]};

   task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: drains immediate checks and scores every valid pulse against the queue.
   initial begin : monitor
      exp_t e;
      chk_t c;
      int ld_acc, chi_acc;
      logic [1:0] dor_acc;
      ld_acc = 0; chi_acc = 0; dor_acc = 2'b00;
      forever begin
         @(negedge clk);
         while (chkq.size() > 0) begin
            c = chkq.pop_front();
            cmp(c.name, c.act, c.exp);
         end
         if (!rst_n) begin
            ld_acc = 0; chi_acc = 0; dor_acc = 2'b00;
         end else begin
            if (bus.sr_load) ld_acc++;
            if (bus.sr_clk) chi_acc++;
            dor_acc = dor_acc | bus.sr_data_out;
            if (bus.valid) begin
               vcnt++;
               if (sbq.size() == 0) begin
                  cmp("unexpected_valid", 64'd1, 64'd0);
               end else begin
                  e = sbq.pop_front();
                  cmp({e.tag, " latency"},  64'(cyc - e.base), 64'(e.lat));
                  cmp({e.tag, " dout"},     64'(bus.dout), 64'(e.dout));
                  cmp({e.tag, " mismatch"}, 64'(bus.mismatch), 64'(e.mm));
                  cmp({e.tag, " chains"},   64'({chain1, chain0}), 64'(e.chain));
                  cmp({e.tag, " load_cyc"}, 64'(ld_acc), 64'(e.ld));
                  cmp({e.tag, " sclk_hi"},  64'(chi_acc), 64'(e.chi));
                  cmp({e.tag, " data_act"}, 64'(dor_acc), 64'(e.dor));
               end
               ld_acc = 0; chi_acc = 0; dor_acc = 2'b00;
            end
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      chk_t c;
      c.name = name; c.act = act; c.exp = exp;
      chkq.push_back(c);
   endtask

   task automatic issue(input string tag, input logic [15:0] d, input logic [1:0] m,
                        input logic [5:0] dv, input int lat, input logic [15:0] xd,
                        input logic [1:0] xm, input logic [15:0] xc, input logic [1:0] xo);
      exp_t e;
      @(negedge clk);
      bus.din = d; bus.ch_mask = m; bus.div = dv;
      e.tag = tag; e.base = cyc; e.lat = lat; e.dout = xd; e.mm = xm;
      e.chain = xc; e.ld = 2 * (1 << dv); e.chi = 8 * (1 << dv); e.dor = xo;
      sbq.push_back(e);
      v0 = vcnt;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic wait_valid(input string tag);
      for (int i = 0; i < 3000 && vcnt == v0; i++) begin
         @(negedge clk);
         #1;
      end
      if (vcnt == v0) chk({tag, " valid_timeout"}, 64'd0, 64'd1);
   endtask

   function automatic logic [63:0] outs_all();
      return 64'({bus.sr_clk, bus.sr_data_out, bus.sr_load, bus.busy,
                  bus.valid, bus.dout, bus.mismatch});
   endfunction

   initial begin : stim
      int low;
      rst_n = 1'b0;
      bus.start = 1'b0; bus.din = '0; bus.ch_mask = '0; bus.div = '0;
`ifdef SR_LOOPBACK_EN
      bus.loopback = 1'b0;
`endif
      pv0 = 8'h00; pv1 = 8'h00; preset = 1'b1;
      repeat (3) @(negedge clk);
      preset = 1'b0;
      chk("reset_outputs", outs_all(), 64'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Basic write into empty chains: not yet armed.
      issue("basic", 16'hA53C, 2'b11, 6'd0, 19, 16'h0000, 2'b00, 16'hA53C, 2'b11);
      wait_valid("basic");

      // Readback of the previous write matches its shadow.
      issue("readback", 16'hFF00, 2'b11, 6'd0, 19, 16'hA53C, 2'b00, 16'hFF00, 2'b10);
      wait_valid("readback");

      // Corrupt chain 1, then expect a channel-1 mismatch.
      @(negedge clk);
      pv0 = 8'h00; pv1 = 8'hA4; preset = 1'b1;
      @(negedge clk);
      preset = 1'b0;
      issue("corrupt", 16'hFF00, 2'b11, 6'd0, 19, 16'hA400, 2'b10, 16'hFF00, 2'b10);
      wait_valid("corrupt");

      // Channel 1 masked, H = 4: dout[15:8] held, chain 1 fills with zeros.
      issue("mask_div", 16'h1234, 2'b01, 6'd2, 73, 16'hA400, 2'b00, 16'h0034, 2'b01);
      wait_valid("mask_div");

      // Start while busy is ignored; busy stays high through the valid cycle.
      @(negedge clk);
      chk("busy_before_start", 64'(bus.busy), 64'd0);
      issue("busy_ign", 16'h7788, 2'b11, 6'd0, 19, 16'h0034, 2'b10, 16'h7788, 2'b11);
      low = 0;
      for (int k = 1; k < 200; k++) begin
         #1;
         if (bus.valid) break;
         if (!bus.busy) low++;
         if (k == 5) begin bus.start = 1'b1; bus.din = 16'h1122; end
         if (k == 6) bus.start = 1'b0;
         @(negedge clk);
      end
      chk("busy_low_cycles", 64'(low), 64'd0);
      chk("busy_at_valid", 64'(bus.busy), 64'd1);
      @(negedge clk);
      #1;
      chk("busy_after_done", 64'(bus.busy), 64'd0);
      repeat (60) @(negedge clk);
      chk("valid_pulses", 64'(vcnt - v0), 64'd1);

      // Reset at cycle 7 of a transaction: three bits have reached each chain.
      @(negedge clk);
      bus.din = 16'hABCD; bus.ch_mask = 2'b11; bus.div = 6'd0;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (6) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_outputs", outs_all(), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("abort_no_valid", 64'(sbq.size()), 64'd0);

      // After reset: full-length timing, disarmed compare, partial chain contents read back.
      issue("post_reset", 16'h0FF0, 2'b11, 6'd0, 19, 16'hBD46, 2'b00, 16'h0FF0, 2'b11);
      wait_valid("post_reset");

`ifdef SR_LOOPBACK_EN
      // Loopback capture sees the written word regardless of chain contents.
      @(negedge clk);
      bus.loopback = 1'b1;
      issue("loopback", 16'h5AC3, 2'b11, 6'd0, 19, 16'h5AC3, 2'b11, 16'h5AC3, 2'b11);
      wait_valid("loopback");
      bus.loopback = 1'b0;
`endif

      repeat (5) @(negedge clk);
      chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
